// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared sizes, source indices and helpers for the write-back arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int N_SRC = 3;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_FPU = 2;

    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

    // True when at least two request bits are set (clearing the lowest set bit leaves something).
    function automatic logic multi_req(input logic [N_SRC-1:0] req);
        return (req & (req - N_SRC'(1))) != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : N-way request to one-hot grant. Round-robin when RR_ARB_EN is
//            defined, otherwise fixed priority with the lowest index winning.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N = N_SRC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] w_base;
    logic [PW-1:0] w_gidx;
    logic          w_any;

    // Scan from the base index upward, wrapping, and take the first requester.
    always_comb begin
        int idx;
        grant  = '0;
        w_any  = 1'b0;
        w_gidx = '0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(w_base) + k) % N;
            if (!w_any && req[idx]) begin
                grant[idx] = 1'b1;
                w_any      = 1'b1;
                w_gidx     = PW'(idx);
            end
        end
    end

`ifdef RR_ARB_EN
    logic [PW-1:0] r_ptr;

    assign w_base = r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);
        end
    end
`else
    logic w_unused;

    assign w_base   = '0;
    assign w_unused = ^{clk, rst, w_gidx, w_any};
`endif

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Shares the int_reg and float_reg write ports among ALU/LSU/FPU
//            write-back sources. Define RR_ARB_EN for round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import wb_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      src_valid,
    input  logic [N_SRC-1:0]      src_is_fp,
    input  logic [N_SRC*AW-1:0]   src_addr,
    input  logic [N_SRC*XLEN-1:0] src_data,
    output logic [N_SRC-1:0]      src_ready,
    output logic                  int_we,
    output logic [AW-1:0]         int_waddr,
    output logic [XLEN-1:0]       int_wdata,
    output logic                  fp_we,
    output logic [AW-1:0]         fp_waddr,
    output logic [XLEN-1:0]       fp_wdata,
    output logic [15:0]           conflict_cnt
);

    logic [N_SRC-1:0] w_int_req;
    logic [N_SRC-1:0] w_fp_req;
    logic [N_SRC-1:0] w_int_gnt;
    logic [N_SRC-1:0] w_fp_gnt;
    logic [AW-1:0]    w_int_addr;
    logic [AW-1:0]    w_fp_addr;
    logic [XLEN-1:0]  w_int_data;
    logic [XLEN-1:0]  w_fp_data;
    logic [1:0]       w_cnt_inc;
    logic [16:0]      w_cnt_sum;

    logic             r_int_we;
    logic [AW-1:0]    r_int_waddr;
    logic [XLEN-1:0]  r_int_wdata;
    logic             r_fp_we;
    logic [AW-1:0]    r_fp_waddr;
    logic [XLEN-1:0]  r_fp_wdata;
    logic [15:0]      r_conflict_cnt;

    assign w_int_req = src_valid & ~src_is_fp;
    assign w_fp_req  = src_valid &  src_is_fp;

    rr_arbiter #(.N(N_SRC)) u_int_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (w_int_req),
        .grant (w_int_gnt)
    );

    rr_arbiter #(.N(N_SRC)) u_fp_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (w_fp_req),
        .grant (w_fp_gnt)
    );

    // Grants are subsets of the requests, so an idle source never sees ready.
    assign src_ready = rst ? '0 : (w_int_gnt | w_fp_gnt);

    always_comb begin
        w_int_addr = '0;
        w_int_data = '0;
        w_fp_addr  = '0;
        w_fp_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_int_gnt[i]) begin
                w_int_addr = src_addr[i*AW +: AW];
                w_int_data = src_data[i*XLEN +: XLEN];
            end
            if (w_fp_gnt[i]) begin
                w_fp_addr = src_addr[i*AW +: AW];
                w_fp_data = src_data[i*XLEN +: XLEN];
            end
        end
    end

    assign w_cnt_inc = {1'b0, multi_req(w_int_req)} + {1'b0, multi_req(w_fp_req)};
    assign w_cnt_sum = {1'b0, r_conflict_cnt} + {15'b0, w_cnt_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_we       <= 1'b0;
            r_int_waddr    <= '0;
            r_int_wdata    <= '0;
            r_fp_we        <= 1'b0;
            r_fp_waddr     <= '0;
            r_fp_wdata     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            // x0 is hardwired: the handshake completes but nothing is written.
            r_int_we <= (|w_int_gnt) && (w_int_addr != '0);
            r_fp_we  <= |w_fp_gnt;
            if (|w_int_gnt) begin
                r_int_waddr <= w_int_addr;
                r_int_wdata <= w_int_data;
            end
            if (|w_fp_gnt) begin
                r_fp_waddr <= w_fp_addr;
                r_fp_wdata <= w_fp_data;
            end
            r_conflict_cnt <= (w_cnt_sum > {1'b0, CONFLICT_MAX}) ? CONFLICT_MAX
                                                                 : w_cnt_sum[15:0];
        end
    end

    assign int_we       = r_int_we;
    assign int_waddr    = r_int_waddr;
    assign int_wdata    = r_int_wdata;
    assign fp_we        = r_fp_we;
    assign fp_waddr     = r_fp_waddr;
    assign fp_wdata     = r_fp_wdata;
    assign conflict_cnt = r_conflict_cnt;

    // A waiting source must keep valid and its payload steady until granted.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src_proto
        a_src_stable : assert property (
            @(posedge clk) disable iff (rst)
            (src_valid[gi] && !src_ready[gi]) |=>
                (src_valid[gi] && $stable(src_is_fp[gi]) &&
                 $stable(src_addr[gi*AW +: AW]) && $stable(src_data[gi*XLEN +: XLEN]))
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Self-checking bench for rf_wb_arbiter against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;
    import wb_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        src_valid;
    logic [2:0]        src_is_fp;
    logic [14:0]       src_addr;
    logic [95:0]       src_data;
    logic [2:0]        src_ready;
    logic              int_we, fp_we;
    logic [4:0]        int_waddr, fp_waddr;
    logic [31:0]       int_wdata, fp_wdata;
    logic [15:0]       conflict_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: what the write ports should show after the last edge.
    int          m_int_ptr, m_fp_ptr, m_cnt;
    logic        m_int_we, m_fp_we;
    logic [4:0]  m_int_waddr, m_fp_waddr;
    logic [31:0] m_int_wdata, m_fp_wdata;
    // Prediction for the current cycle's inputs.
    logic [2:0]  e_ready;
    int          n_int_ptr, n_fp_ptr, n_cnt;
    logic        n_int_we, n_fp_we;
    logic [4:0]  n_int_waddr, n_fp_waddr;
    logic [31:0] n_int_wdata, n_fp_wdata;

    rf_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_is_fp    (src_is_fp),
        .src_addr     (src_addr),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .int_we       (int_we),
        .int_waddr    (int_waddr),
        .int_wdata    (int_wdata),
        .fp_we        (fp_we),
        .fp_waddr     (fp_waddr),
        .fp_wdata     (fp_wdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [2:0] req, input int start);
        for (int k = 0; k < 3; k++) begin
            if (req[(start + k) % 3]) return (start + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_int_ptr = 0; m_fp_ptr = 0; m_cnt = 0;
        m_int_we = 1'b0; m_fp_we = 1'b0;
        m_int_waddr = '0; m_fp_waddr = '0; m_int_wdata = '0; m_fp_wdata = '0;
    endtask

    task automatic model_eval();
        logic [2:0] ir, fr;
        int gi, gf;
        ir = src_valid & ~src_is_fp;
        fr = src_valid & src_is_fp;
`ifdef RR_ARB_EN
        gi = pick(ir, m_int_ptr);
        gf = pick(fr, m_fp_ptr);
`else
        gi = pick(ir, 0);
        gf = pick(fr, 0);
`endif
        e_ready = '0;
        n_int_ptr = m_int_ptr; n_fp_ptr = m_fp_ptr;
        n_int_we = 1'b0; n_fp_we = 1'b0;
        n_int_waddr = m_int_waddr; n_int_wdata = m_int_wdata;
        n_fp_waddr = m_fp_waddr; n_fp_wdata = m_fp_wdata;
        if (gi >= 0) begin
            e_ready[gi] = 1'b1;
            n_int_waddr = src_addr[gi*5 +: 5];
            n_int_wdata = src_data[gi*32 +: 32];
            n_int_we    = (n_int_waddr != 5'd0);
            n_int_ptr   = (gi + 1) % 3;
        end
        if (gf >= 0) begin
            e_ready[gf] = 1'b1;
            n_fp_waddr = src_addr[gf*5 +: 5];
            n_fp_wdata = src_data[gf*32 +: 32];
            n_fp_we    = 1'b1;
            n_fp_ptr   = (gf + 1) % 3;
        end
        n_cnt = m_cnt + int'($countones(ir) >= 2) + int'($countones(fr) >= 2);
        if (n_cnt > 65535) n_cnt = 65535;
    endtask

    task automatic settle();
        #3;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_int_ptr = n_int_ptr; m_fp_ptr = n_fp_ptr; m_cnt = n_cnt;
        m_int_we = n_int_we; m_fp_we = n_fp_we;
        m_int_waddr = n_int_waddr; m_int_wdata = n_int_wdata;
        m_fp_waddr = n_fp_waddr; m_fp_wdata = n_fp_wdata;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        src_valid = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic refresh(input int i);
        src_valid[i] = ($urandom_range(0, 9) < 7);
        src_is_fp[i] = 1'($urandom_range(0, 1));
        src_addr[i*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        src_data[i*32 +: 32] = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_valid = 3'b111; src_is_fp = 3'b010; src_addr = '0; src_data = '0;
        model_reset();
        #12;
        checks++;
        if (src_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", src_ready); end
        checks++;
        if ({int_we, fp_we, int_waddr, fp_waddr, int_wdata, fp_wdata, conflict_cnt} !== 92'd0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b/%b waddr=%h/%h wdata=%h/%h cnt=%h want all zero",
                     int_we, fp_we, int_waddr, fp_waddr, int_wdata, fp_wdata, conflict_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        src_valid = 3'b111; src_is_fp = 3'b000;
        src_addr = {5'd9, 5'd8, 5'd7}; src_data = {32'hC, 32'hB, 32'hA};
        // Build up some state, then hit reset mid-run with every source valid.
        for (int c = 0; c < 2; c++) begin
            settle(); tick();
        end
        checks++;
        if (conflict_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL pre_reset_cnt got %0d want %0d", conflict_cnt, m_cnt); end
        src_valid = 3'b111; src_is_fp = 3'($urandom_range(0, 7));
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({src_ready, int_we, fp_we, conflict_cnt} !== 21'd0) begin
            errors++;
            $display("FAIL midrun_reset got ready=%b int_we=%b fp_we=%b cnt=%0d want 0", src_ready, int_we, fp_we, conflict_cnt);
        end
        src_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        src_valid = 3'b001; src_is_fp = 3'b000;
        src_addr[4:0] = 5'd5; src_data[31:0] = 32'hDEADBEEF;
        settle();
        checks++;
        if (src_ready !== 3'b001) begin errors++; $display("FAIL single_ready got %b want 001", src_ready); end
        tick();
        src_valid = '0;
        checks++;
        if ({int_we, int_waddr, int_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_write got we=%b addr=%0d data=%h want 1/5/deadbeef", int_we, int_waddr, int_wdata);
        end
        settle(); tick();
        checks++;
        if (int_we !== 1'b0) begin errors++; $display("FAIL single_we_drop got %b want 0", int_we); end
    endtask

    task automatic test_parallel();
        int c0;
        c0 = m_cnt;
        src_valid = 3'b101; src_is_fp = 3'b100;
        src_addr[4:0] = 5'd3; src_addr[14:10] = 5'd7;
        src_data[31:0] = $urandom; src_data[95:64] = $urandom;
        settle();
        checks++;
        if (src_ready !== 3'b101) begin errors++; $display("FAIL parallel_ready got %b want 101", src_ready); end
        tick();
        src_valid = '0;
        checks++;
        if ({int_we, int_waddr, int_wdata, fp_we, fp_waddr, fp_wdata} !==
            {1'b1, 5'd3, src_data[31:0], 1'b1, 5'd7, src_data[95:64]}) begin
            errors++;
            $display("FAIL parallel_write got int=%b/%0d/%h fp=%b/%0d/%h want int=1/3/%h fp=1/7/%h",
                     int_we, int_waddr, int_wdata, fp_we, fp_waddr, fp_wdata, src_data[31:0], src_data[95:64]);
        end
        checks++;
        if (conflict_cnt !== 16'(c0)) begin errors++; $display("FAIL parallel_cnt got %0d want %0d", conflict_cnt, c0); end
    endtask

    task automatic test_contention();
        int c0;
        logic [2:0] exp_g;
        logic fpu_seen;
        do_reset();
        c0 = m_cnt;
        src_valid = 3'b111; src_is_fp = 3'b000;
        src_addr = {5'd12, 5'd11, 5'd10};
        src_data = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        for (int k = 0; k < 3; k++) begin
            exp_g = 3'(1 << k);
            settle();
            checks++;
            if (src_ready !== exp_g || e_ready !== exp_g) begin
                errors++;
                $display("FAIL contention_grant%0d got %b want %b", k, src_ready, exp_g);
            end
            tick();
            src_valid = src_valid & ~exp_g;
            checks++;
            if ({int_we, int_waddr, conflict_cnt} !== {1'b1, 5'(10 + k), 16'(c0 + ((k < 2) ? k + 1 : 2))}) begin
                errors++;
                $display("FAIL contention_out%0d got we=%b addr=%0d cnt=%0d want 1/%0d/%0d",
                         k, int_we, int_waddr, conflict_cnt, 10 + k, c0 + ((k < 2) ? k + 1 : 2));
            end
        end
        // ALU re-presents every cycle while the FPU waits on the same port.
        fpu_seen = 1'b0;
        src_valid = 3'b101; src_is_fp = 3'b000;
        for (int k = 0; k < 8; k++) begin
            settle();
            checks++;
            if (src_ready !== e_ready) begin errors++; $display("FAIL starve_ready%0d got %b want %b", k, src_ready, e_ready); end
            if (src_ready[2]) fpu_seen = 1'b1;
            tick();
            if (e_ready[2]) src_valid[2] = 1'b0;
            src_valid[0] = 1'b1;
            src_data[31:0] = $urandom;
        end
`ifdef RR_ARB_EN
        checks++;
        if (fpu_seen !== 1'b1) begin errors++; $display("FAIL rr_no_starve got fpu_granted=%b want 1", fpu_seen); end
`else
        checks++;
        if (fpu_seen !== 1'b0) begin errors++; $display("FAIL fixed_starve got fpu_granted=%b want 0", fpu_seen); end
`endif
        do_reset();
    endtask

    task automatic test_x0();
        src_valid = 3'b010; src_is_fp = 3'b000;
        src_addr[9:5] = 5'd0; src_data[63:32] = 32'h1234;
        settle();
        checks++;
        if (src_ready !== 3'b010) begin errors++; $display("FAIL x0_int_ready got %b want 010", src_ready); end
        tick();
        checks++;
        if (int_we !== 1'b0) begin errors++; $display("FAIL x0_int_we got %b want 0", int_we); end
        src_is_fp = 3'b010;
        settle();
        checks++;
        if (src_ready !== 3'b010) begin errors++; $display("FAIL x0_fp_ready got %b want 010", src_ready); end
        tick();
        src_valid = '0;
        checks++;
        if ({fp_we, fp_waddr, fp_wdata} !== {1'b1, 5'd0, 32'h1234}) begin
            errors++;
            $display("FAIL x0_fp_write got we=%b addr=%0d data=%h want 1/0/1234", fp_we, fp_waddr, fp_wdata);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) refresh(i);
        for (int c = 0; c < 400; c++) begin
            settle();
            checks++;
            if (src_ready !== e_ready) begin errors++; $display("FAIL rand_ready c%0d got %b want %b", c, src_ready, e_ready); end
            tick();
            checks++;
            if (int_we !== m_int_we || (m_int_we && {int_waddr, int_wdata} !== {m_int_waddr, m_int_wdata})) begin
                errors++;
                $display("FAIL rand_int c%0d got %b/%0d/%h want %b/%0d/%h", c, int_we, int_waddr, int_wdata, m_int_we, m_int_waddr, m_int_wdata);
            end
            checks++;
            if (fp_we !== m_fp_we || (m_fp_we && {fp_waddr, fp_wdata} !== {m_fp_waddr, m_fp_wdata})) begin
                errors++;
                $display("FAIL rand_fp c%0d got %b/%0d/%h want %b/%0d/%h", c, fp_we, fp_waddr, fp_wdata, m_fp_we, m_fp_waddr, m_fp_wdata);
            end
            checks++;
            if (conflict_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt c%0d got %0d want %0d", c, conflict_cnt, m_cnt); end
            for (int i = 0; i < 3; i++) begin
                if (!src_valid[i] || e_ready[i]) refresh(i);
            end
        end
        do_reset();
    endtask

    task automatic test_saturation();
        logic [15:0] prev;
        src_valid = 3'b111; src_is_fp = 3'b000;
        src_addr = {5'd2, 5'd1, 5'd4};
        prev = conflict_cnt;
        for (int c = 0; c < 70000; c++) begin
            settle(); tick();
            checks++;
            if (conflict_cnt !== 16'(m_cnt) || conflict_cnt < prev) begin
                errors++;
                $display("FAIL sat_cnt c%0d got %0d want %0d (prev %0d)", c, conflict_cnt, m_cnt, prev);
            end
            prev = conflict_cnt;
        end
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_final got %h want ffff", conflict_cnt); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_parallel();
        test_contention();
        test_x0();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
